// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern driver.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } led_mode_t;

  localparam int PERIOD_W = 16;

endpackage

// File: rtl/led_pattern_driver_if.sv
// Configuration handshake: the host is master, the driver is slave.
interface led_pattern_driver_if #(
  parameter int N_LEDS   = 5,
  parameter int PWM_BITS = 4
);
  import led_pkg::*;

  logic                cfg_valid;
  logic                cfg_ready;
  led_mode_t           cfg_mode;
  logic [N_LEDS-1:0]   cfg_pattern;
  logic [PERIOD_W-1:0] cfg_period;
  logic [PWM_BITS-1:0] cfg_duty;

  modport master (
    output cfg_valid, cfg_mode, cfg_pattern, cfg_period, cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_pattern, cfg_period, cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/led_tick_gen.sv
// Prescaler: one-cycle tick every CLK_HZ/TICK_HZ clocks, restartable via clr_i.
module led_tick_gen #(
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_pattern_driver.sv
// N-channel LED driver: static/blink/chase/bounce patterns with PWM dimming.
// Define LED_ACTIVE_LOW_EN to invert the leds output register (1 = dark).
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int                N_LEDS        = 5,
  parameter int                CLK_HZ        = 12000000,
  parameter int                TICK_HZ       = 1000,
  parameter int                PWM_BITS      = 4,
  parameter logic [N_LEDS-1:0] RESET_PATTERN = 5'b10101
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_pattern_driver_if.slave  cfg,
  output logic                 step,
  output logic [N_LEDS-1:0]    leds
);
  localparam int              POS_W   = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);
`ifdef LED_ACTIVE_LOW_EN
  localparam logic [N_LEDS-1:0] LEDS_RST = '1;
`else
  localparam logic [N_LEDS-1:0] LEDS_RST = '0;
`endif

  led_mode_t           mode_q, mode_d;
  logic [N_LEDS-1:0]   pattern_q, pattern_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PERIOD_W-1:0] tmr_q, tmr_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [N_LEDS-1:0]   chase_q, chase_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [N_LEDS-1:0]   leds_q, leds_d;
  logic                ready_q, ready_d;
  logic                step_q, step_d;
  logic                phase_q, phase_d;
  logic                dir_up_q, dir_up_d;

  logic                accept, tick, gate;
  logic [PERIOD_W-1:0] last_tick;
  logic [N_LEDS-1:0]   chase_rot, onehot, raw;

  assign accept = cfg.cfg_valid & ready_q;

  led_tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .tick_o (tick)
  );

  generate
    if (N_LEDS > 1) begin : g_rot
      assign chase_rot = {chase_q[N_LEDS-2:0], chase_q[N_LEDS-1]};
    end else begin : g_norot
      assign chase_rot = chase_q;
    end
  endgenerate

  // A programmed period of 0 behaves like 1.
  assign last_tick = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern_q;
    period_d  = period_q;
    duty_d    = duty_q;
    tmr_d     = tmr_q;
    chase_d   = chase_q;
    pos_d     = pos_q;
    phase_d   = phase_q;
    dir_up_d  = dir_up_q;
    ready_d   = 1'b1;
    step_d    = 1'b0;
    pwm_d     = pwm_q + PWM_BITS'(1);

    if (tick) begin
      step_d = (tmr_q == last_tick);
      tmr_d  = step_d ? '0 : tmr_q + PERIOD_W'(1);
    end

    if (step_q) begin
      phase_d = ~phase_q;
      chase_d = chase_rot;
      if (N_LEDS > 1) begin
        if (dir_up_q) begin
          if (pos_q == POS_MAX) begin
            pos_d    = pos_q - POS_W'(1);
            dir_up_d = 1'b0;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end else begin
          if (pos_q == '0) begin
            pos_d    = pos_q + POS_W'(1);
            dir_up_d = 1'b1;
          end else begin
            pos_d = pos_q - POS_W'(1);
          end
        end
      end
    end

    // A new configuration overrides any coincident step and restarts all timing.
    if (accept) begin
      mode_d    = cfg.cfg_mode;
      pattern_d = cfg.cfg_pattern;
      period_d  = cfg.cfg_period;
      duty_d    = cfg.cfg_duty;
      tmr_d     = '0;
      step_d    = 1'b0;
      phase_d   = 1'b0;
      chase_d   = cfg.cfg_pattern;
      pos_d     = '0;
      dir_up_d  = 1'b1;
      pwm_d     = '0;
    end

    onehot        = '0;
    onehot[pos_q] = 1'b1;
    case (mode_q)
      MODE_BLINK:  raw = phase_q ? pattern_q : '0;
      MODE_CHASE:  raw = chase_q;
      MODE_BOUNCE: raw = onehot;
      default:     raw = pattern_q;
    endcase

    gate = (duty_q == '1) || (pwm_q < duty_q);
`ifdef LED_ACTIVE_LOW_EN
    leds_d = ~(raw & {N_LEDS{gate}});
`else
    leds_d = raw & {N_LEDS{gate}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_STATIC;
      pattern_q <= RESET_PATTERN;
      period_q  <= PERIOD_W'(1);
      duty_q    <= '1;
      tmr_q     <= '0;
      pwm_q     <= '0;
      chase_q   <= RESET_PATTERN;
      pos_q     <= '0;
      phase_q   <= 1'b0;
      dir_up_q  <= 1'b1;
      ready_q   <= 1'b0;
      step_q    <= 1'b0;
      leds_q    <= LEDS_RST;
    end else begin
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      tmr_q     <= tmr_d;
      pwm_q     <= pwm_d;
      chase_q   <= chase_d;
      pos_q     <= pos_d;
      phase_q   <= phase_d;
      dir_up_q  <= dir_up_d;
      ready_q   <= ready_d;
      step_q    <= step_d;
      leds_q    <= leds_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign step          = step_q;
  assign leds          = leds_q;
endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver at DIV=10, N_LEDS=5, PWM_BITS=4.
module tb_led_pattern_driver;
  import led_pkg::*;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [4:0] POL = 5'b11111;
`else
  localparam logic [4:0] POL = 5'b00000;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       step;
  logic [4:0] leds;
  int         n_assert = 0;
  int         n_fail   = 0;
  int         lit;

  led_pattern_driver_if #(.N_LEDS(5), .PWM_BITS(4)) cfg_if ();

  led_pattern_driver #(
    .N_LEDS(5), .CLK_HZ(100), .TICK_HZ(10), .PWM_BITS(4), .RESET_PATTERN(5'b10101)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cfg   (cfg_if),
    .step  (step),
    .leds  (leds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_leds(input string tag, input logic [4:0] exp);
    chk(tag, 32'(leds), 32'(exp ^ POL));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_cfg(input led_mode_t m, input logic [4:0] p,
                        input logic [15:0] per, input logic [3:0] d);
    cfg_if.cfg_mode    = m;
    cfg_if.cfg_pattern = p;
    cfg_if.cfg_period  = per;
    cfg_if.cfg_duty    = d;
    cfg_if.cfg_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_if.cfg_valid   = 1'b0;
    $display("cfg accepted: mode=%0d pattern=%b period=%0d duty=%0d", m, p, per, d);
  endtask

  task automatic count_lit(input int n);
    lit = 0;
    for (int k = 1; k <= n; k++) begin
      cyc(1);
      if (leds === (5'b11111 ^ POL)) lit++;
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_mode    = MODE_STATIC;
    cfg_if.cfg_pattern = '0;
    cfg_if.cfg_period  = '0;
    cfg_if.cfg_duty    = '0;

    // Reset and default STATIC behaviour
    repeat (3) @(negedge clk);
    chk_leds("rst_leds", 5'b00000);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
    rst_n = 1'b1;
    cyc(1); chk("ready_after_rel", 32'(cfg_if.cfg_ready), 32'd1);
    cyc(1); chk_leds("rst_pattern", 5'b10101);
    cyc(7); chk("rst_step_e9", 32'(step), 32'd0);
    cyc(1); chk("rst_step_e10", 32'(step), 32'd1);
    cyc(1); chk("rst_step_e11", 32'(step), 32'd0);
    cyc(9); chk("rst_step_e20", 32'(step), 32'd1);

    // BLINK, period 2
    do_cfg(MODE_BLINK, 5'b00111, 16'd2, 4'd15);
    cyc(1);  chk_leds("blink_a1", 5'b00000);
    cyc(18); chk("blink_step_a19", 32'(step), 32'd0);
    cyc(1);  chk("blink_step_a20", 32'(step), 32'd1);
    cyc(1);  chk_leds("blink_a21", 5'b00000);
    cyc(1);  chk_leds("blink_a22", 5'b00111);
    cyc(8);  chk("blink_step_a30", 32'(step), 32'd0);
    cyc(10); chk("blink_step_a40", 32'(step), 32'd1);
    cyc(1);  chk_leds("blink_a41", 5'b00111);
    cyc(1);  chk_leds("blink_a42", 5'b00000);

    // CHASE, period 1
    do_cfg(MODE_CHASE, 5'b00001, 16'd1, 4'd15);
    cyc(11); chk_leds("chase_a11", 5'b00001);
    cyc(1);  chk_leds("chase_a12", 5'b00010);
    cyc(10); chk_leds("chase_a22", 5'b00100);
    cyc(10); chk_leds("chase_a32", 5'b01000);
    cyc(10); chk_leds("chase_a42", 5'b10000);
    cyc(9);  chk_leds("chase_a51", 5'b10000);
    cyc(1);  chk_leds("chase_a52", 5'b00001);

    // BOUNCE, period 1; the pattern argument must be ignored
    do_cfg(MODE_BOUNCE, 5'b11111, 16'd1, 4'd15);
    cyc(2);  chk_leds("bounce_a2", 5'b00001);
    cyc(9);  chk_leds("bounce_a11", 5'b00001);
    cyc(1);  chk_leds("bounce_a12", 5'b00010);
    cyc(10); chk_leds("bounce_a22", 5'b00100);
    cyc(10); chk_leds("bounce_a32", 5'b01000);
    cyc(9);  chk_leds("bounce_a41", 5'b01000);
    cyc(1);  chk_leds("bounce_a42", 5'b10000);
    cyc(9);  chk_leds("bounce_a51", 5'b10000);
    cyc(1);  chk_leds("bounce_a52", 5'b01000);
    cyc(10); chk_leds("bounce_a62", 5'b00100);
    cyc(10); chk_leds("bounce_a72", 5'b00010);
    cyc(10); chk_leds("bounce_a82", 5'b00001);
    cyc(10); chk_leds("bounce_a92", 5'b00010);

    // PWM: lit for the first 4 of 16 counter values after accept
    do_cfg(MODE_STATIC, 5'b11111, 16'd1, 4'd4);
    cyc(1); chk_leds("pwm4_a1", 5'b11111);
    cyc(3); chk_leds("pwm4_a4", 5'b11111);
    cyc(1); chk_leds("pwm4_a5", 5'b00000);
    count_lit(16); chk("pwm4_lit_of_16", 32'(lit), 32'd4);
    do_cfg(MODE_STATIC, 5'b11111, 16'd1, 4'd0);
    count_lit(16); chk("pwm0_lit_of_16", 32'(lit), 32'd0);
    do_cfg(MODE_STATIC, 5'b11111, 16'd1, 4'd15);
    count_lit(16); chk("pwm15_lit_of_16", 32'(lit), 32'd16);

    // Accept on the step cycle: no rotation, full period to next step
    do_cfg(MODE_CHASE, 5'b00001, 16'd1, 4'd15);
    cyc(10); chk("coll_step_seen", 32'(step), 32'd1);
    do_cfg(MODE_CHASE, 5'b00011, 16'd1, 4'd15);
    chk("coll_step_dropped", 32'(step), 32'd0);
    cyc(1); chk_leds("coll_b1", 5'b00011);
    cyc(1); chk_leds("coll_b2", 5'b00011);
    cyc(7); chk("coll_step_b9", 32'(step), 32'd0);
    cyc(1); chk("coll_step_b10", 32'(step), 32'd1);
    cyc(1); chk_leds("coll_b11", 5'b00011);
    cyc(1); chk_leds("coll_b12", 5'b00110);

    // Asynchronous reset in the middle of BLINK
    do_cfg(MODE_BLINK, 5'b00111, 16'd1, 4'd15);
    cyc(13); chk_leds("midrst_lit", 5'b00111);
    #2 rst_n = 1'b0;
    #1;
    chk_leds("midrst_async_leds", 5'b00000);
    chk("midrst_async_ready", 32'(cfg_if.cfg_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);  chk_leds("midrst_pattern", 5'b10101);
    cyc(8);  chk("midrst_step_e10", 32'(step), 32'd1);
    cyc(20); chk_leds("midrst_static", 5'b10101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
